// File: rtl/ysyx_22051013_wbu.sv
// ysyx_22051013_wbu -- write-back unit for the riscv64 core.
//
// Merges single-cycle ALU results and buffered LSU/MDU results onto the
// register file's single write port. LSU results always pass through a
// small FIFO. Each cycle at most one result commits, and the write port
// outputs are registered.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data      ALU result in, alu_ready handshake out
//   lsu_valid/lsu_rd/lsu_data      LSU result in, lsu_ready handshake out
//   waddr/wdata/wen                register-file write port (registered)
//   lsu_cnt                        LSU FIFO occupancy
//   retire_cnt                     committed result count (x0 included)
module ysyx_22051013_wbu #(
  parameter  int LSU_DEPTH = 2,
  localparam int PW        = $clog2(LSU_DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [4:0]    alu_rd,
  input  logic [63:0]   alu_data,
  output logic          alu_ready,
  input  logic          lsu_valid,
  input  logic [4:0]    lsu_rd,
  input  logic [63:0]   lsu_data,
  output logic          lsu_ready,
  output logic [4:0]    waddr,
  output logic [63:0]   wdata,
  output logic          wen,
  output logic [CW-1:0] lsu_cnt,
  output logic [63:0]   retire_cnt
);

  logic          wen_q,    wen_d;
  logic [4:0]    waddr_q,  waddr_d;
  logic [63:0]   wdata_q,  wdata_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [PW-1:0] wptr_q,   wptr_d;
  logic [PW-1:0] rptr_q,   rptr_d;
  logic [63:0]   retire_q, retire_d;
  logic [4:0]    mem_rd_q   [LSU_DEPTH];
  logic [4:0]    mem_rd_d   [LSU_DEPTH];
  logic [63:0]   mem_data_q [LSU_DEPTH];
  logic [63:0]   mem_data_d [LSU_DEPTH];

  logic full;
  logic push;
  logic lsu_win;
  logic alu_win;

  always_comb begin
    full      = (cnt_q == CW'(LSU_DEPTH));
    // Readies look only at registered occupancy, so a pop in this cycle
    // never opens a slot for a push in the same cycle.
    alu_ready = !rst && !full;
    lsu_ready = !rst && (cnt_q < CW'(LSU_DEPTH));
    push      = lsu_valid && lsu_ready;
    // A full FIFO always wins, which bounds the ALU stall to one cycle.
    lsu_win   = !rst && (full || ((cnt_q != '0) && !alu_valid));
    alu_win   = !rst && !lsu_win && alu_valid;
  end

  always_comb begin
    wen_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    retire_d   = retire_q;
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;

    if (rst) begin
      waddr_d  = '0;
      wdata_d  = '0;
      cnt_d    = '0;
      wptr_d   = '0;
      rptr_d   = '0;
      retire_d = '0;
    end else begin
      if (lsu_win) begin
        waddr_d  = mem_rd_q[rptr_q];
        wdata_d  = mem_data_q[rptr_q];
        wen_d    = (mem_rd_q[rptr_q] != 5'd0);
        rptr_d   = rptr_q + PW'(1);
        retire_d = retire_q + 64'd1;
      end else if (alu_win) begin
        waddr_d  = alu_rd;
        wdata_d  = alu_data;
        wen_d    = (alu_rd != 5'd0);
        retire_d = retire_q + 64'd1;
      end

      if (push) begin
        mem_rd_d[wptr_q]   = lsu_rd;
        mem_data_d[wptr_q] = lsu_data;
        wptr_d             = wptr_q + PW'(1);
      end

      case ({push, lsu_win})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    wen_q      <= wen_d;
    waddr_q    <= waddr_d;
    wdata_q    <= wdata_d;
    cnt_q      <= cnt_d;
    wptr_q     <= wptr_d;
    rptr_q     <= rptr_d;
    retire_q   <= retire_d;
    mem_rd_q   <= mem_rd_d;
    mem_data_q <= mem_data_d;
  end

  assign wen        = wen_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign lsu_cnt    = cnt_q;
  assign retire_cnt = retire_q;

endmodule
